zverif_mmio_hub: RTL and testbench

Memory-mapped I/O hub for the Verilator verification top: an AXI-Lite slave that sits on the interconnect's external master port and fans CPU accesses out to `NUM_CHAN` outward-facing channels. Each channel has a buffered CPU-to-host TX stream and a single-entry host-to-CPU RX stream. Reads are fully supported, and every channel also has a status register. It generalises the single write-only control port into a parametrised, bidirectional, backpressured multi-channel block.

---
 rtl/zverif_mmio_hub_pkg.sv | 35 +++
 rtl/zverif_mmio_hub_if.sv | 38 +++
 rtl/zverif_sync_fifo.sv | 59 +++++
 rtl/zverif_mmio_hub.sv | 192 +++++++++++++++++++
 tb/tb_zverif_mmio_hub.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/zverif_mmio_hub_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// zverif_mmio_pkg : register offsets, response codes, FSM states, STATUS layout
// Rev 1.0
// ----------------------------------------------------------------------------
package zverif_mmio_pkg;

    localparam logic [7:0] OFF_DATA   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_CNT_LSB  = 8;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_RESP = 1'b1} rd_state_t;

    function automatic logic [31:0] status_word(input logic full, input logic held,
                                                input logic empty, input logic [7:0] cnt);
        logic [31:0] w_s;
        w_s                       = '0;
        w_s[STAT_TX_FULL]         = full;
        w_s[STAT_RX_VALID]        = held;
        w_s[STAT_TX_EMPTY]        = empty;
        w_s[STAT_CNT_LSB +: 8]    = cnt;
        return w_s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zverif_mmio_hub_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// zverif_mmio_hub_if : AXI-Lite bus bundle with master/slave views
// Rev 1.0
// ----------------------------------------------------------------------------
interface zverif_mmio_hub_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/zverif_sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// zverif_sync_fifo : single-clock FIFO with registered occupancy count
// Rev 1.0
// ----------------------------------------------------------------------------
module zverif_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     resetn,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         push_data,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         head,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (PW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/zverif_mmio_hub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// zverif_mmio_hub : AXI-Lite slave fanning out to per-channel TX FIFOs / RX regs
// Rev 1.0
// ----------------------------------------------------------------------------
module zverif_mmio_hub
    import zverif_mmio_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int NUM_CHAN        = 2,
    parameter int CHAN_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  wire logic                         clk,
    input  wire logic                         resetn,
    zverif_mmio_hub_if.slave                  s_axil,
    output logic      [NUM_CHAN-1:0]          tx_valid,
    input  wire logic [NUM_CHAN-1:0]          tx_ready,
    output logic      [NUM_CHAN*DATA_WIDTH-1:0] tx_data,
    input  wire logic [NUM_CHAN-1:0]          rx_valid,
    output logic      [NUM_CHAN-1:0]          rx_ready,
    input  wire logic [NUM_CHAN*DATA_WIDTH-1:0] rx_data
);
    localparam int          CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] c_chan_en  = (NUM_CHAN >= 16) ? 16'hFFFF : 16'((1 << NUM_CHAN) - 1);

    wr_state_t r_wr_state;
    rd_state_t r_rd_state;
    logic        r_bvalid, r_arready, r_rvalid;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata;

    logic [NUM_CHAN-1:0] w_full, w_empty, w_push, r_held, w_rx_pop;
    logic [CNT_W-1:0]    w_count [NUM_CHAN];
    logic [31:0]         r_hold  [NUM_CHAN];
    logic [15:0]         w_full_ext, w_empty_ext, w_held_ext;
    logic [7:0]          w_cnt_ext  [16];
    logic [31:0]         w_hold_ext [16];

    logic [3:0]                 w_wr_ch, w_rd_ch;
    logic [CHAN_ADDR_WIDTH-1:0] w_wr_off, w_rd_off;
    logic w_wr_is_data, w_wr_hit, w_wr_accept, w_rd_is_data, w_rd_is_status, w_ar_fire;
    logic [31:0] w_rd_data;
    logic [1:0]  w_rd_resp;
    logic        w_rd_pop;
    logic        w_unused_bits;

    assign w_wr_ch  = s_axil.awaddr[CHAN_ADDR_WIDTH +: 4];
    assign w_wr_off = s_axil.awaddr[CHAN_ADDR_WIDTH-1:0];
    assign w_rd_ch  = s_axil.araddr[CHAN_ADDR_WIDTH +: 4];
    assign w_rd_off = s_axil.araddr[CHAN_ADDR_WIDTH-1:0];
    assign w_unused_bits = ^{s_axil.awaddr, s_axil.araddr, s_axil.wstrb};

    assign w_wr_is_data   = c_chan_en[w_wr_ch] && (w_wr_off == CHAN_ADDR_WIDTH'(OFF_DATA));
    assign w_wr_hit       = w_wr_is_data ||
                            (c_chan_en[w_wr_ch] && (w_wr_off == CHAN_ADDR_WIDTH'(OFF_STATUS)));
    assign w_rd_is_data   = c_chan_en[w_rd_ch] && (w_rd_off == CHAN_ADDR_WIDTH'(OFF_DATA));
    assign w_rd_is_status = c_chan_en[w_rd_ch] && (w_rd_off == CHAN_ADDR_WIDTH'(OFF_STATUS));

    // AW and W are only taken together, and never into a full target FIFO.
    assign w_wr_accept = (r_wr_state == W_IDLE) && s_axil.awvalid && s_axil.wvalid &&
                         !(w_wr_is_data && w_full_ext[w_wr_ch]);
    assign w_ar_fire   = r_arready && s_axil.arvalid;

    assign s_axil.awready = w_wr_accept;
    assign s_axil.wready  = w_wr_accept;
    assign s_axil.bvalid  = r_bvalid;
    assign s_axil.bresp   = r_bresp;
    assign s_axil.arready = r_arready;
    assign s_axil.rvalid  = r_rvalid;
    assign s_axil.rresp   = r_rresp;
    assign s_axil.rdata   = r_rdata;

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        assign w_push[c]   = w_wr_accept && w_wr_is_data && (w_wr_ch == 4'(c));
        assign w_rx_pop[c] = w_ar_fire && w_rd_pop && (w_rd_ch == 4'(c));
        assign tx_valid[c] = ~w_empty[c];
        assign rx_ready[c] = ~r_held[c];

        zverif_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
            .clk       (clk),
            .resetn    (resetn),
            .push      (w_push[c]),
            .push_data (s_axil.wdata),
            .pop       (tx_ready[c]),
            .head      (tx_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .full      (w_full[c]),
            .empty     (w_empty[c]),
            .count     (w_count[c])
        );

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_held[c] <= 1'b0;
                r_hold[c] <= '0;
            end else if (rx_valid[c] && !r_held[c]) begin
                r_held[c] <= 1'b1;
                r_hold[c] <= rx_data[c*DATA_WIDTH +: DATA_WIDTH];
            end else if (w_rx_pop[c]) begin
                r_held[c] <= 1'b0;
            end
        end
    end

    // Pad per-channel state to 16 entries so the 4-bit channel index never overruns.
    for (genvar c = 0; c < 16; c++) begin : g_ext
        if (c < NUM_CHAN) begin : g_live
            assign w_full_ext[c]  = w_full[c];
            assign w_empty_ext[c] = w_empty[c];
            assign w_held_ext[c]  = r_held[c];
            assign w_cnt_ext[c]   = 8'(w_count[c]);
            assign w_hold_ext[c]  = r_hold[c];
        end else begin : g_pad
            assign w_full_ext[c]  = 1'b0;
            assign w_empty_ext[c] = 1'b0;
            assign w_held_ext[c]  = 1'b0;
            assign w_cnt_ext[c]   = '0;
            assign w_hold_ext[c]  = '0;
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_DECERR;
        w_rd_pop  = 1'b0;
        if (w_rd_is_data) begin
            if (w_held_ext[w_rd_ch]) begin
                w_rd_data = w_hold_ext[w_rd_ch];
                w_rd_resp = RESP_OKAY;
                w_rd_pop  = 1'b1;
            end else begin
                w_rd_resp = RESP_SLVERR;
            end
        end else if (w_rd_is_status) begin
            w_rd_data = status_word(w_full_ext[w_rd_ch], w_held_ext[w_rd_ch],
                                    w_empty_ext[w_rd_ch], w_cnt_ext[w_rd_ch]);
            w_rd_resp = RESP_OKAY;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_state <= W_IDLE;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            case (r_wr_state)
                W_IDLE: if (w_wr_accept) begin
                    r_wr_state <= W_RESP;
                    r_bvalid   <= 1'b1;
                    r_bresp    <= w_wr_hit ? RESP_OKAY : RESP_DECERR;
                end
                W_RESP: if (s_axil.bready) begin
                    r_wr_state <= W_IDLE;
                    r_bvalid   <= 1'b0;
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    // arready is registered so it stays low while reset is held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: if (w_ar_fire) begin
                    r_rd_state <= R_RESP;
                    r_arready  <= 1'b0;
                    r_rvalid   <= 1'b1;
                    r_rresp    <= w_rd_resp;
                    r_rdata    <= w_rd_data;
                end else begin
                    r_arready  <= 1'b1;
                end
                R_RESP: if (s_axil.rready) begin
                    r_rd_state <= R_IDLE;
                    r_arready  <= 1'b1;
                    r_rvalid   <= 1'b0;
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_zverif_mmio_hub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_zverif_mmio_hub : directed scoreboard bench for the MMIO hub
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_zverif_mmio_hub;
    import zverif_mmio_pkg::*;

    localparam int NCH = 2;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic [NCH-1:0]    tx_valid, tx_ready, rx_valid, rx_ready;
    logic [NCH*32-1:0] tx_data, rx_data;

    zverif_mmio_hub_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil ();

    zverif_mmio_hub #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_CHAN(NCH), .CHAN_ADDR_WIDTH(4), .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .s_axil   (axil),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int wr_done  = 0;
    int rd_done  = 0;

    logic [1:0]  exp_b[$];
    logic [1:0]  exp_rresp[$];
    logic [31:0] exp_rdata[$];
    logic [1:0]  mon_b, mon_rr;
    logic [31:0] mon_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: a beat transfers at the next posedge when valid & ready at negedge.
    always @(negedge clk) begin
        if (resetn && axil.bvalid && axil.bready) begin
            n_checks++;
            if (exp_b.size() == 0) begin
                n_errors++;
                $display("FAIL bresp_unexpected: got bresp=%0d, expected no response", axil.bresp);
            end else begin
                mon_b = exp_b.pop_front();
                if (axil.bresp !== mon_b) begin
                    n_errors++;
                    $display("FAIL bresp: got %0d, expected %0d", axil.bresp, mon_b);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && axil.rvalid && axil.rready) begin
            n_checks++;
            if (exp_rresp.size() == 0) begin
                n_errors++;
                $display("FAIL rresp_unexpected: got rdata=0x%08h rresp=%0d, expected no response",
                         axil.rdata, axil.rresp);
            end else begin
                mon_rr = exp_rresp.pop_front();
                mon_rd = exp_rdata.pop_front();
                if (axil.rresp !== mon_rr || axil.rdata !== mon_rd) begin
                    n_errors++;
                    $display("FAIL rdata_rresp: got 0x%08h/%0d, expected 0x%08h/%0d",
                             axil.rdata, axil.rresp, mon_rd, mon_rr);
                end
            end
        end
    end

    // Both bus tasks are entered just after a posedge and return just after the handshake edge.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] exp);
        bit ok;
        exp_b.push_back(exp);
        axil.awaddr = a; axil.wdata = d; axil.wstrb = 4'hF;
        axil.awvalid = 1'b1; axil.wvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = axil.awready && axil.wready;
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL aw_timeout: got no awready for addr 0x%08h, expected handshake", a);
        end
        @(posedge clk); #1;
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        wr_done++;
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] exp);
        bit ok;
        exp_rdata.push_back(d);
        exp_rresp.push_back(exp);
        axil.araddr = a; axil.arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = axil.arready;
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL ar_timeout: got no arready for addr 0x%08h, expected handshake", a);
        end
        @(posedge clk); #1;
        axil.arvalid = 1'b0;
        rd_done++;
    endtask

    task automatic wait_bvalid(input string name);
        for (int i = 0; i < 50 && !axil.bvalid; i++) @(negedge clk);
        chk(name, 32'(axil.bvalid), 32'd1);
    endtask

    initial begin
        int base_w, base_r;
        axil.awaddr = '0; axil.awvalid = 1'b0; axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 1'b0;
        axil.bready = 1'b1; axil.araddr = '0; axil.arvalid = 1'b0; axil.rready = 1'b1;
        tx_ready = '0; rx_valid = '0; rx_data = '0;

        // Reset values
        #1 resetn = 1'b0;
        @(negedge clk);
        chk("rst_bvalid",  32'(axil.bvalid),  32'd0);
        chk("rst_rvalid",  32'(axil.rvalid),  32'd0);
        chk("rst_arready", 32'(axil.arready), 32'd0);
        chk("rst_awready", 32'(axil.awready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid),    32'd0);
        chk("rst_rx_ready", 32'(rx_ready),    32'd3);
        chk("rst_rdata",   axil.rdata,        32'd0);
        chk("rst_resp",    32'({axil.bresp, axil.rresp}), 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;
        chk("idle_arready", 32'(axil.arready), 32'd1);

        // ch1 DATA write, visible at N+1, popped at N+2
        tx_ready[1] = 1'b1;
        axi_write(32'h10, 32'hDEADBEEF, RESP_OKAY);
        chk("t1_tx_valid", 32'(tx_valid[1]), 32'd1);
        chk("t1_tx_data",  tx_data[63:32],   32'hDEADBEEF);
        @(posedge clk); #1;
        chk("t1_popped",   32'(tx_valid[1]), 32'd0);
        tx_ready[1] = 1'b0;

        // Fill ch0, stall the fifth write, release with a one-cycle tx_ready pulse
        for (int i = 0; i < 4; i++) axi_write(32'h00, 32'h100 + 32'(i), RESP_OKAY);
        base_w = wr_done;
        fork
            axi_write(32'h00, 32'h105, RESP_OKAY);
        join_none
        repeat (2) @(negedge clk);
        chk("t2_stall_awready", 32'(axil.awready), 32'd0);
        @(posedge clk); #1;
        axi_read(32'h04, 32'h0000_0401, RESP_OKAY);
        chk("t2_still_stalled", 32'(wr_done - base_w), 32'd0);
        tx_ready[0] = 1'b1;
        @(posedge clk); #1;
        tx_ready[0] = 1'b0;
        @(negedge clk);
        chk("t2_fifth_awready", 32'(axil.awready), 32'd1);
        @(posedge clk); #1;
        chk("t2_fifth_done", 32'(wr_done - base_w), 32'd1);
        tx_ready[0] = 1'b1;
        chk("t2_head0", tx_data[31:0], 32'h101);
        @(posedge clk); #1;
        chk("t2_head1", tx_data[31:0], 32'h102);
        @(posedge clk); #1;
        chk("t2_head2", tx_data[31:0], 32'h103);
        @(posedge clk); #1;
        chk("t2_head3", tx_data[31:0], 32'h105);
        @(posedge clk); #1;
        tx_ready[0] = 1'b0;
        chk("t2_drained", 32'(tx_valid[0]), 32'd0);

        // RX holding register
        rx_data[31:0] = 32'h12345678; rx_valid[0] = 1'b1;
        @(posedge clk); #1;
        rx_valid[0] = 1'b0;
        chk("t3_rx_ready_low", 32'(rx_ready[0]), 32'd0);
        axi_read(32'h04, 32'h0000_0006, RESP_OKAY);
        axi_read(32'h00, 32'h12345678, RESP_OKAY);
        chk("t3_rx_ready_back", 32'(rx_ready[0]), 32'd1);
        axi_read(32'h00, 32'h0, RESP_SLVERR);

        // Decode errors and STATUS write
        axi_write(32'h0C, 32'hCAFE0001, RESP_DECERR);
        axi_read (32'h0C, 32'h0, RESP_DECERR);
        axi_write(32'h20, 32'hCAFE0002, RESP_DECERR);
        axi_read (32'h20, 32'h0, RESP_DECERR);
        axi_write(32'h04, 32'hCAFE0003, RESP_OKAY);
        chk("t4_no_fifo_change", 32'(tx_valid), 32'd0);
        axi_read (32'h14, 32'h0000_0004, RESP_OKAY);

        // bready held low: bvalid holds, awready stays low, a read completes alongside
        axil.bready = 1'b0;
        base_w = wr_done; base_r = rd_done;
        fork
            axi_write(32'h10, 32'hA5, RESP_OKAY);
        join_none
        wait_bvalid("t5_bvalid_up");
        @(posedge clk); #1;
        fork
            axi_write(32'h10, 32'hA6, RESP_OKAY);
            axi_read (32'h14, 32'h0000_0100, RESP_OKAY);
        join_none
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_bvalid_hold",  32'(axil.bvalid),  32'd1);
            chk("t5_awready_hold", 32'(axil.awready), 32'd0);
        end
        @(posedge clk); #1;
        axil.bready = 1'b1;
        for (int i = 0; i < 20 && (wr_done - base_w < 2 || rd_done - base_r < 1); i++) @(posedge clk);
        #1;
        chk("t5_all_done", 32'((wr_done - base_w) + (rd_done - base_r)), 32'd3);
        chk("t5_ch1_head", tx_data[63:32], 32'hA5);
        tx_ready[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1 tx_ready[1] = 1'b0;

        // Reset with a pending response and three buffered entries
        axi_write(32'h00, 32'h201, RESP_OKAY);
        axi_write(32'h00, 32'h202, RESP_OKAY);
        axil.bready = 1'b0;
        fork
            axi_write(32'h00, 32'h203, RESP_OKAY);
        join_none
        wait_bvalid("t6_bvalid_up");
        resetn = 1'b0;
        #1;
        chk("t6_bvalid_async",   32'(axil.bvalid), 32'd0);
        chk("t6_tx_valid_async", 32'(tx_valid),    32'd0);
        exp_b.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        axil.bready = 1'b1;
        @(posedge clk); #1;
        axi_read(32'h04, 32'h0000_0004, RESP_OKAY);
        repeat (3) @(posedge clk);

        chk("end_b_queue", 32'(exp_b.size()),     32'd0);
        chk("end_r_queue", 32'(exp_rresp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, expected $finish before 200000");
        $fatal(1);
    end
endmodule
`default_nettype wire
